instr_fetch: RTL and testbench

- Instruction fetch stage and reader of the 8-bit-address, 16-bit-word combinational program ROM.
- Holds the program counter, drives the ROM address, and registers the returned word into a one-entry output buffer.
- Presents that word to decode with a valid/ready handshake.
- Supports branch redirect with flush, a run gate, halt detection, and a saturating count of accepted instructions.

---
 rtl/instr_fetch.sv | 177 +++++++++++++++++
 tb/tb_instr_fetch.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Purpose:
//   Instruction fetch stage in front of a combinational program ROM. It keeps
//   the program counter and drives it straight onto the ROM address. The word
//   the ROM returns is captured into a one-entry output buffer, which decode
//   drains through a valid/ready handshake. The stage also supports:
//     - branch redirect with flush,
//     - a level-sensitive run gate,
//     - halt detection on a reserved instruction word,
//     - a saturating count of accepted instructions.
//
// Ports:
//   clk            in   rising-edge clock for all state
//   reset          in   synchronous, active-high reset (overrides everything)
//   run            in   fetch enable, level-sensitive
//   rom_addr       out  ROM address, driven directly by the pc register
//   rom_data       in   ROM word for rom_addr, valid in the same cycle
//   instr_out      out  registered instruction word
//   instr_pc       out  address instr_out was fetched from
//   instr_valid    out  instr_out holds an unconsumed instruction
//   instr_ready    in   decode accepts instr_out this cycle
//   redirect_valid in   branch/jump redirect request
//   redirect_pc    in   redirect target address
//   halted         out  high while the FSM is in HALTED
//   fetch_count    out  accepted handshakes, saturating at 16'hFFFF
//   fsm_state      out  current FSM state encoding (debug visibility)
//
// Handshake:
//   A transfer happens on a rising edge where instr_valid && instr_ready.
//   Once instr_valid is high, instr_out and instr_pc hold until that transfer
//   happens. Only a redirect or a reset can drop a pending word without a
//   transfer. The producer never withdraws a word on its own.
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int unsigned          ADDR_W     = 8,
  parameter int unsigned          INSTR_W    = 16,
  parameter logic [ADDR_W-1:0]    RESET_PC   = 8'h00,
  parameter logic [INSTR_W-1:0]   HALT_INSTR = 16'h0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               halted,
  output logic [15:0]        fetch_count,
  output logic [1:0]         fsm_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] pc;

  // Decoded per-cycle controls, produced by the output process.
  logic load;
  logic xfer;
  logic halt_word;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    if (redirect_valid) begin
      // A redirect leaves any state, including HALTED.
      state_next = run ? ST_FETCH : ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          // The first load can happen on the same edge that leaves IDLE.
          // If that first word is the halt word, go straight to HALTED.
          if (run) begin
            state_next = (load && halt_word) ? ST_HALTED : ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (!run) begin
            state_next = ST_IDLE;
          end else if (load && halt_word) begin
            state_next = ST_HALTED;
          end
        end
        ST_HALTED: begin
          state_next = ST_HALTED;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output / control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    xfer      = instr_valid && instr_ready;
    halt_word = (rom_data == HALT_INSTR);
    // The buffer can take a new word when it is empty, or when its current
    // word leaves this same cycle. Taking the new word in that second case
    // keeps the stream bubble-free. HALTED never loads. A redirect cycle
    // never loads either: the target is fetched on the following edge.
    load      = ((state == ST_FETCH) || (state == ST_IDLE && run)) &&
                run && (!instr_valid || instr_ready) && !redirect_valid;
    halted    = (state == ST_HALTED);
    fsm_state = state;
  end

  // The ROM sees the pc register directly; there is no logic on this path.
  assign rom_addr = pc;

  // ---------------------------------------------------------------------------
  // Program counter and output buffer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      instr_out   <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (redirect_valid) begin
      // Flush: the pending word is discarded.
      pc          <= redirect_pc;
      instr_valid <= 1'b0;
    end else if (load) begin
      instr_out   <= rom_data;
      instr_pc    <= pc;
      instr_valid <= 1'b1;
      // The halt word freezes pc at its own address. Otherwise pc wraps
      // naturally at the top of the address space.
      if (!halt_word) begin
        pc <= pc + 1'b1;
      end
    end else if (xfer) begin
      instr_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Accepted-instruction counter
  // ---------------------------------------------------------------------------
  // A transfer in a redirect cycle still counts: decode consumed that word
  // before the flush took effect.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= '0;
    end else if (xfer && (fetch_count != 16'hFFFF)) begin
      fetch_count <= fetch_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed bench for instr_fetch. The ROM is modelled as an array that is
// read combinationally. Inputs change 1 time unit after a rising edge.
// Outputs are checked at that same point, once the edge has settled.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT signals
  // ---------------------------------------------------------------------------
  logic               clk = 1'b0;
  logic               reset;
  logic               run;
  logic [ADDR_W-1:0]  rom_addr;
  logic [INSTR_W-1:0] rom_data;
  logic [INSTR_W-1:0] instr_out;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               halted;
  logic [15:0]        fetch_count;
  logic [1:0]         fsm_state;

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Program ROM model
  // ---------------------------------------------------------------------------
  logic [INSTR_W-1:0] rom [0:255];

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[8'h00] = 16'hC000;
    rom[8'h01] = 16'hC801;
    rom[8'h02] = 16'hD002;
    for (int i = 3; i < 16; i++) rom[i] = 16'hA000 | 16'(i);
    rom[8'h10] = 16'h0000;
    rom[8'hFF] = 16'h9800;
  end

  assign rom_data = rom[rom_addr];

  instr_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .run            (run),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .fetch_count    (fetch_count),
    .fsm_state      (fsm_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and helpers
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the full visible output state in one call.
  task automatic check_out(input string tag, input logic v,
                           input logic [15:0] ins, input logic [7:0] ipc,
                           input logic [7:0] addr, input logic [15:0] cnt,
                           input logic hlt, input logic [1:0] st);
    check({tag, ".valid"}, 32'(instr_valid), 32'(v));
    if (v) begin
      check({tag, ".instr"}, 32'(instr_out), 32'(ins));
      check({tag, ".ipc"},   32'(instr_pc),  32'(ipc));
    end
    check({tag, ".addr"},  32'(rom_addr),    32'(addr));
    check({tag, ".count"}, 32'(fetch_count), 32'(cnt));
    check({tag, ".halt"},  32'(halted),      32'(hlt));
    check({tag, ".state"}, 32'(fsm_state),   32'(st));
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b1; run = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    step();
    // Reset state
    check("rst.out", 32'(instr_out), 32'h0);
    check("rst.pc",  32'(instr_pc),  32'h0);
    check_out("rst", 1'b0, 16'h0, 8'h00, 8'h00, 16'd0, 1'b0, S_IDLE);

    // Stream: valid rises on the first edge with run high.
    reset = 1'b0; run = 1'b1; instr_ready = 1'b1;
    step();
    check_out("s0", 1'b1, 16'hC000, 8'h00, 8'h01, 16'd0, 1'b0, S_FETCH);
    step();
    check_out("s1", 1'b1, 16'hC801, 8'h01, 8'h02, 16'd1, 1'b0, S_FETCH);

    // Stall for 4 cycles: everything holds.
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_out("stall", 1'b1, 16'hC801, 8'h01, 8'h02, 16'd1, 1'b0, S_FETCH);
    end
    instr_ready = 1'b1;
    step();
    check_out("s2", 1'b1, 16'hD002, 8'h02, 8'h03, 16'd2, 1'b0, S_FETCH);
    step();
    check_out("s3", 1'b1, 16'hA003, 8'h03, 8'h04, 16'd3, 1'b0, S_FETCH);

    // Run up to the halt word at 8'h10.
    for (int a = 4; a < 16; a++) begin
      step();
      check_out("walk", 1'b1, 16'hA000 | 16'(a), 8'(a), 8'(a + 1),
                16'(a), 1'b0, S_FETCH);
    end
    step();
    check_out("halt", 1'b1, 16'h0000, 8'h10, 8'h10, 16'd16, 1'b1, S_HALTED);
    step();
    check_out("haltacc", 1'b0, 16'h0, 8'h0, 8'h10, 16'd17, 1'b1, S_HALTED);
    step();
    check_out("haltidle", 1'b0, 16'h0, 8'h0, 8'h10, 16'd17, 1'b1, S_HALTED);

    // Redirect out of HALTED to 8'hFF; pc then wraps to 8'h00.
    redirect_valid = 1'b1; redirect_pc = 8'hFF;
    step();
    check_out("redir", 1'b0, 16'h0, 8'h0, 8'hFF, 16'd17, 1'b0, S_FETCH);
    redirect_valid = 1'b0;
    step();
    check_out("rFF", 1'b1, 16'h9800, 8'hFF, 8'h00, 16'd17, 1'b0, S_FETCH);
    step();
    check_out("wrap", 1'b1, 16'hC000, 8'h00, 8'h01, 16'd18, 1'b0, S_FETCH);

    // Redirect while a word is pending and stalled: the word is dropped.
    instr_ready = 1'b0;
    step();
    check_out("pend", 1'b1, 16'hC000, 8'h00, 8'h01, 16'd18, 1'b0, S_FETCH);
    redirect_valid = 1'b1; redirect_pc = 8'h05;
    step();
    check_out("flush", 1'b0, 16'h0, 8'h0, 8'h05, 16'd18, 1'b0, S_FETCH);
    redirect_valid = 1'b0; instr_ready = 1'b1;
    step();
    check_out("tgt", 1'b1, 16'hA005, 8'h05, 8'h06, 16'd18, 1'b0, S_FETCH);

    // Reset in mid-stream with a valid word.
    reset = 1'b1;
    step();
    check("rst2.out", 32'(instr_out), 32'h0);
    check("rst2.pc",  32'(instr_pc),  32'h0);
    check_out("rst2", 1'b0, 16'h0, 8'h00, 8'h00, 16'd0, 1'b0, S_IDLE);

    // run=0 with a word pending: it is held, then accepted, with no new load.
    reset = 1'b0; run = 1'b1;
    step();
    check_out("r1", 1'b1, 16'hC000, 8'h00, 8'h01, 16'd0, 1'b0, S_FETCH);
    run = 1'b0; instr_ready = 1'b0;
    step();
    check_out("r0hold", 1'b1, 16'hC000, 8'h00, 8'h01, 16'd0, 1'b0, S_IDLE);
    instr_ready = 1'b1;
    step();
    check_out("r0acc", 1'b0, 16'h0, 8'h0, 8'h01, 16'd1, 1'b0, S_IDLE);
    step();
    check_out("r0idle", 1'b0, 16'h0, 8'h0, 8'h01, 16'd1, 1'b0, S_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
